// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: operation encoding (funct3),
// FSM state encoding and the op-class helper.
package mdu_pkg;

  typedef logic [31:0] data_t;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } mdu_state_e;

  function automatic logic is_div(input mdu_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/mdu_div.sv
// Restoring radix-2 divider on unsigned magnitudes, one quotient bit per cycle.
// The first step is taken on the start edge; quotient/remainder are the
// outputs of the step in progress and are final in the cycle done is high.
module mdu_div #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  logic [XLEN-1:0]  rem_q, quo_q, dvs_q;
  logic [XLEN-1:0]  src_rem, src_quo, src_dvs, rem_n, quo_n;
  logic [XLEN:0]    shifted, diff;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  always_comb begin
    src_rem = start ? '0 : rem_q;
    src_quo = start ? dividend : quo_q;
    src_dvs = start ? divisor : dvs_q;
    shifted = {src_rem, src_quo[XLEN-1]};
    diff    = shifted - {1'b0, src_dvs};
    // A borrow out of the trial subtraction means restore the shifted value.
    if (diff[XLEN]) begin
      rem_n = shifted[XLEN-1:0];
      quo_n = {src_quo[XLEN-2:0], 1'b0};
    end else begin
      rem_n = diff[XLEN-1:0];
      quo_n = {src_quo[XLEN-2:0], 1'b1};
    end
  end

  assign busy      = busy_q;
  assign done      = busy_q && (cnt_q == LAST);
  assign quotient  = quo_n;
  assign remainder = rem_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else if (abort) begin
      busy_q <= 1'b0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= CNT_W'(1);
      rem_q  <= rem_n;
      quo_q  <= quo_n;
      dvs_q  <= divisor;
    end else if (busy_q) begin
      rem_q <= rem_n;
      quo_q <= quo_n;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/mdu.sv
// RV32M/RV64M multiply/divide unit: FSM, sign handling, special cases, multiply.
// Build option MDU_FAST_MUL_EN selects a single-cycle multiplier instead of shift-add.
module mdu
  import mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e       state, state_n;
  mdu_op_e          op, op_q;
  logic [CNT_W-1:0] cnt;
  logic             accept, load, res_neg, res_neg_q, iterative, calc_last;
  logic             signed_a, signed_b, a_neg, b_neg, div_zero, overflow, special;
  logic [XLEN-1:0]  mag_a, mag_b, special_res, quick_res, div_res, result_n;
  logic             div_start, div_busy, div_done;
  logic [XLEN-1:0]  div_quo, div_rem;

  function automatic logic [XLEN-1:0] mul_select(input mdu_op_e o, input logic neg,
                                                 input logic [2*XLEN-1:0] mag);
    logic [2*XLEN-1:0] p;
    p = neg ? -mag : mag;
    return (o == OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  // Handshake: a request transfers on an edge with in_valid && in_ready (and no
  // flush); a result transfers on an edge with out_valid && out_ready. Both
  // ready/valid outputs decode the registered state only.
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready && !flush;
  assign op        = mdu_op_e'(in_op);

  always_comb begin
    signed_a = op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    signed_b = op inside {OP_MULH, OP_DIV, OP_REM};
    a_neg    = signed_a && in_a[XLEN-1];
    b_neg    = signed_b && in_b[XLEN-1];
    mag_a    = a_neg ? -in_a : in_a;
    mag_b    = b_neg ? -in_b : in_b;
    div_zero = is_div(op) && (in_b == '0);
    overflow = (op inside {OP_DIV, OP_REM}) && (in_a == MOST_NEG) && (in_b == '1);
    special  = div_zero || overflow;
    res_neg  = (op inside {OP_REM, OP_REMU}) ? a_neg : (a_neg ^ b_neg);
    if (op inside {OP_DIV, OP_DIVU}) special_res = div_zero ? '1 : in_a;
    else                             special_res = div_zero ? in_a : '0;
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
  assign iterative = is_div(op) && !special;
  assign quick_res = special ? special_res : mul_select(op, a_neg ^ b_neg, fast_prod);
  assign calc_last = (cnt == LAST) && div_busy && div_done;
`else
  logic [XLEN-1:0]   mcand_q, mul_res;
  logic [2*XLEN-1:0] prod_q, prod_n;

  // One shift-add step: conditionally add the multiplicand into the high half,
  // then shift the whole product/multiplier register right by one.
  function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] p,
                                                 input logic [XLEN-1:0] mc);
    logic [XLEN:0] sum;
    sum = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, mc} : {(XLEN+1){1'b0}});
    return {sum, p[XLEN-1:1]};
  endfunction

  assign prod_n    = accept ? mul_step({{XLEN{1'b0}}, mag_b}, mag_a) : mul_step(prod_q, mcand_q);
  assign mul_res   = mul_select(op_q, res_neg_q, prod_n);
  assign iterative = !special;
  assign quick_res = special_res;
  assign calc_last = (cnt == LAST) && (!is_div(op_q) || (div_busy && div_done));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q <= '0;
      prod_q  <= '0;
    end else if (accept && !is_div(op)) begin
      mcand_q <= mag_a;
      prod_q  <= prod_n;
    end else if (state == S_CALC) begin
      prod_q <= prod_n;
    end
  end
`endif

  assign div_start = accept && is_div(op) && !special;

  mdu_div #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (flush),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    if (op_q inside {OP_REM, OP_REMU}) div_res = res_neg_q ? -div_rem : div_rem;
    else                               div_res = res_neg_q ? -div_quo : div_quo;
  end

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    result_n = out_result;
    if (flush) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          if (iterative) begin
            state_n = S_CALC;
          end else begin
            state_n  = S_DONE;
            load     = 1'b1;
            result_n = quick_res;
          end
        end
        S_CALC: if (calc_last) begin
          state_n = S_DONE;
          load    = 1'b1;
`ifdef MDU_FAST_MUL_EN
          result_n = div_res;
`else
          result_n = is_div(op_q) ? div_res : mul_res;
`endif
        end
        S_DONE:  if (out_ready) state_n = S_IDLE;
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      out_result <= '0;
      out_tag    <= '0;
      op_q       <= OP_MUL;
      res_neg_q  <= 1'b0;
    end else begin
      state <= state_n;
      if (load) out_result <= result_n;
      // The counter holds the number of iteration steps already taken.
      if (accept) begin
        cnt       <= CNT_W'(1);
        op_q      <= op;
        res_neg_q <= res_neg;
        out_tag   <= in_tag;
      end else if (state == S_CALC) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
